// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift-register example: transmitter state
// encoding, default word width and the parity helper.
package shiftreg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int SHIFTREG_WIDTH_DEF = 24;

    // Words are zero-extended to this width before the XOR, which leaves parity unchanged.
    localparam int SHIFTREG_PARITY_MAX_W = 64;

    function automatic logic even_parity(input logic [SHIFTREG_PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shiftreg_piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer for gapless frames.
// Optional feature: define SHIFTREG_TX_PARITY_EN to append an even-parity bit to every frame.
module shiftreg_piso_tx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = SHIFTREG_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_parallel_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             dout_serial_o,
    output logic             dout_valid_o,
    output logic             trigger_o,
    output logic             busy_o
);

`ifdef SHIFTREG_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic             ser_q, ser_d;
    logic             val_q, val_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             last_bit;
    logic             data_bit;
    logic             tx_bit;
    logic [WIDTH-1:0] sr_shift;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

    assign din_ready_o = !reset_i && !hold_v_q;
    assign accept      = din_valid_i && din_ready_o;
    assign last_bit    = (cnt_q == LAST_CNT);

    assign data_bit = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
    assign sr_shift = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

`ifdef SHIFTREG_TX_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
    logic par_q, par_d;

    // The parity of each word is captured as it is loaded, since sr is consumed while shifting.
    assign tx_bit = (cnt_q == PAR_CNT) ? par_q : data_bit;

    always_comb begin
        par_d = par_q;
        if (load_en) begin
            par_d = even_parity(SHIFTREG_PARITY_MAX_W'(load_word));
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    assign tx_bit = data_bit;
`endif

    // On the last bit the buffered word wins over a same-cycle accept, which ready already blocks.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        ser_d     = 1'b0;
        val_d     = 1'b0;
        trig_d    = 1'b0;
        load_en   = 1'b0;
        load_word = din_parallel_i;
        busy_d    = (state_q == SHIFT) || hold_v_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_d = tx_bit;
                val_d = 1'b1;
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_ONE;
                if (last_bit) begin
                    trig_d = 1'b1;
                    if (hold_v_q) begin
                        load_en   = 1'b1;
                        load_word = hold_q;
                        hold_v_d  = 1'b0;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (accept) begin
                    hold_d   = din_parallel_i;
                    hold_v_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_en) begin
            sr_d  = load_word;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            ser_q    <= 1'b0;
            val_q    <= 1'b0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            ser_q    <= ser_d;
            val_q    <= val_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
        end
    end

    assign dout_serial_o = ser_q;
    assign dout_valid_o  = val_q;
    assign trigger_o     = trig_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_shiftreg_piso_tx.sv
// Bench for shiftreg_piso_tx: an MSB-first and an LSB-first instance share one stimulus
// stream and are compared against a frame timeline built from accepted words.
module tb_shiftreg_piso_tx;
    import shiftreg_pkg::*;

    localparam int W = SHIFTREG_WIDTH_DEF;
`ifdef SHIFTREG_TX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int MAXE = 16384;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         din_valid_i;
    logic [W-1:0] din_parallel_i;
    logic m_ready, m_ser, m_val, m_trig, m_busy;
    logic l_ready, l_ser, l_val, l_trig, l_busy;

    always #5 clk = ~clk;

    shiftreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut (
        .clk(clk), .reset_i(reset_i), .din_parallel_i(din_parallel_i), .din_valid_i(din_valid_i),
        .din_ready_o(m_ready), .dout_serial_o(m_ser), .dout_valid_o(m_val),
        .trigger_o(m_trig), .busy_o(m_busy)
    );

    shiftreg_piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset_i(reset_i), .din_parallel_i(din_parallel_i), .din_valid_i(din_valid_i),
        .din_ready_o(l_ready), .dout_serial_o(l_ser), .dout_valid_o(l_val),
        .trigger_o(l_trig), .busy_o(l_busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_n   = 0;
    int   last_end = 0;
    int   buf_until = 0;
    int   trig_seen = 0;
    int   val_seen  = 0;
    logic last_acc  = 1'b0;

    // Expected registered outputs per clock edge; a frame occupies FRAME consecutive edges.
    logic exp_v [MAXE];
    logic exp_m [MAXE];
    logic exp_l [MAXE];
    logic exp_t [MAXE];

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] msb_stream;
        logic [W-1:0] lsb_stream;
        logic         par;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    // A word accepted at edge e starts right after the edge, or right after the running frame.
    task automatic schedule(input int e, input logic [W-1:0] w);
        int start;
        int k;
        start = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
        if (start - 1 > e) buf_until = start - 1;
        for (int i = 0; i < FRAME; i++) begin
            k = start + i;
            if (k < MAXE) begin
                exp_v[k] = 1'b1;
                exp_t[k] = (i == FRAME - 1);
                if (i < W) begin
                    exp_m[k] = w[W-1-i];
                    exp_l[k] = w[i];
                end else begin
                    exp_m[k] = ^w;
                    exp_l[k] = ^w;
                end
            end
        end
        last_end = start + FRAME - 1;
    endtask

    task automatic checkOutput(input int e);
        if (e >= MAXE) begin
            check("edge budget", 32'(e), 32'(MAXE - 1));
        end else begin
            check("dout_valid_o", 32'(m_val), 32'(exp_v[e]));
            check("dout_serial_o msb", 32'(m_ser), 32'(exp_m[e]));
            check("trigger_o", 32'(m_trig), 32'(exp_t[e]));
            check("busy_o", 32'(m_busy), 32'(exp_v[e]));
            check("dout_valid_o lsb", 32'(l_val), 32'(exp_v[e]));
            check("dout_serial_o lsb", 32'(l_ser), 32'(exp_l[e]));
            check("trigger_o lsb", 32'(l_trig), 32'(exp_t[e]));
            check("busy_o lsb", 32'(l_busy), 32'(exp_v[e]));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
        int   e;
        logic exp_rdy;
        din_valid_i    = v;
        din_parallel_i = d;
        reset_i        = r;
        #1;
        e = edge_n + 1;
        exp_rdy = !r && !(e <= buf_until);
        check("din_ready_o", 32'(m_ready), 32'(exp_rdy));
        check("din_ready_o lsb", 32'(l_ready), 32'(exp_rdy));
        last_acc = v && exp_rdy;
        @(posedge clk);
        edge_n = e;
        if (r) begin
            for (int k = e; k <= last_end && k < MAXE; k++) begin
                exp_v[k] = 1'b0; exp_m[k] = 1'b0; exp_l[k] = 1'b0; exp_t[k] = 1'b0;
            end
            last_end  = 0;
            buf_until = 0;
        end else if (last_acc) begin
            schedule(e, d);
        end
        #1;
        if (m_trig) trig_seen++;
        if (m_val) val_seen++;
        checkOutput(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           acc_e, first_e, nbits, trig_at, refused, t0, v0;
        logic [W-1:0] got_m, got_l;
        logic         par_m, par_l;

        for (int k = 0; k < MAXE; k++) begin
            exp_v[k] = 1'b0; exp_m[k] = 1'b0; exp_l[k] = 1'b0; exp_t[k] = 1'b0;
        end

        vecs[0] = '{word: 24'hA5C3F0, msb_stream: 24'hA5C3F0, lsb_stream: 24'h0FC3A5, par: 1'b0};
        vecs[1] = '{word: 24'h000003, msb_stream: 24'h000003, lsb_stream: 24'hC00000, par: 1'b0};
        vecs[2] = '{word: 24'h000007, msb_stream: 24'h000007, lsb_stream: 24'hE00000, par: 1'b1};
        vecs[3] = '{word: 24'h000001, msb_stream: 24'h000001, lsb_stream: 24'h800000, par: 1'b1};
        vecs[4] = '{word: 24'h800000, msb_stream: 24'h800000, lsb_stream: 24'h000001, par: 1'b1};
        vecs[5] = '{word: 24'hFFFFFF, msb_stream: 24'hFFFFFF, lsb_stream: 24'hFFFFFF, par: 1'b0};

        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        check("reset valid", 32'(m_val), 32'd0);
        check("reset busy", 32'(m_busy), 32'd0);
        idle(2);

        // Isolated frames: bit order, length, latency, trigger placement and parity.
        foreach (vecs[j]) begin
            applyStimulus(1'b1, vecs[j].word, 1'b0);
            acc_e = edge_n;
            first_e = -1; nbits = 0; trig_at = -1;
            got_m = '0; got_l = '0; par_m = 1'b0; par_l = 1'b0;
            for (int c = 0; c < FRAME + 4; c++) begin
                applyStimulus(1'b0, '0, 1'b0);
                if (m_val) begin
                    if (first_e < 0) first_e = edge_n;
                    if (nbits < W) begin
                        got_m = {got_m[W-2:0], m_ser};
                        got_l = {got_l[W-2:0], l_ser};
                    end else begin
                        par_m = m_ser;
                        par_l = l_ser;
                    end
                    nbits++;
                    if (m_trig) trig_at = nbits;
                end
            end
            check("frame length", 32'(nbits), 32'(FRAME));
            check("first bit latency", 32'(first_e - acc_e), 32'd1);
            check("trigger position", 32'(trig_at), 32'(FRAME));
            check("msb stream", 32'(got_m), 32'(vecs[j].msb_stream));
            check("lsb stream", 32'(got_l), 32'(vecs[j].lsb_stream));
`ifdef SHIFTREG_TX_PARITY_EN
            check("parity bit msb", 32'(par_m), 32'(vecs[j].par));
            check("parity bit lsb", 32'(par_l), 32'(vecs[j].par));
`endif
        end

        // Back-to-back words with valid held high across both accepts.
        t0 = trig_seen; v0 = val_seen;
        applyStimulus(1'b1, 24'h000001, 1'b0);
        applyStimulus(1'b1, 24'h800000, 1'b0);
        check("ready low with buffer full", 32'(m_ready), 32'd0);
        idle(2 * FRAME + 4);
        check("back-to-back valid cycles", 32'(val_seen - v0), 32'(2 * FRAME));
        check("back-to-back triggers", 32'(trig_seen - t0), 32'd2);

        // Third word offered while the buffer is full waits for the first frame's last bit.
        t0 = trig_seen;
        applyStimulus(1'b1, 24'h123456, 1'b0);
        applyStimulus(1'b1, 24'hABCDEF, 1'b0);
        refused = 0;
        last_acc = 1'b0;
        for (int c = 0; c < FRAME + 5 && !last_acc; c++) begin
            applyStimulus(1'b1, 24'h5A5A5A, 1'b0);
            if (!last_acc) refused++;
        end
        check("third word refused cycles", 32'(refused), 32'(FRAME - 1));
        idle(3 * FRAME + 4);
        check("three-word triggers", 32'(trig_seen - t0), 32'd3);

        // Reset in the middle of a frame abandons it without a trigger.
        t0 = trig_seen; v0 = val_seen;
        applyStimulus(1'b1, 24'hC0FFEE, 1'b0);
        for (int c = 0; c < FRAME && (val_seen - v0) < 10; c++) applyStimulus(1'b0, '0, 1'b0);
        check("bits before reset", 32'(val_seen - v0), 32'd10);
        applyStimulus(1'b0, '0, 1'b1);
        check("mid-frame reset valid", 32'(m_val), 32'd0);
        check("mid-frame reset serial", 32'(m_ser), 32'd0);
        check("mid-frame reset trigger", 32'(m_trig), 32'd0);
        check("mid-frame reset busy", 32'(m_busy), 32'd0);
        idle(FRAME + 2);
        check("abandoned frame trigger", 32'(trig_seen - t0), 32'd0);
        v0 = val_seen;
        applyStimulus(1'b1, 24'h0F0F0F, 1'b0);
        idle(FRAME + 3);
        check("fresh frame after reset", 32'(val_seen - v0), 32'(FRAME));
        check("fresh frame trigger", 32'(trig_seen - t0), 32'd1);

        // Random traffic with occasional resets against the timeline model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 199) == 0));
        end
        idle(2 * FRAME + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
